// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// +------------------------------------------------------------------------------------------+
// | keypad_matrix_scanner                                                                     |
// | Scans a ROWS x COLS key matrix, debounces each key and queues press/release events.       |
// | Optional feature macro: KEYPAD_RELEASE_EVT_EN (queue release events as well as presses).  |
// | Revision: 1.0                                                                             |
// +------------------------------------------------------------------------------------------+
module keypad_matrix_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = $clog2(ROWS * COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [COLS-1:0]        keypad_col,
    input  logic [ROWS-1:0]        keypad_row,
    output logic [IDX_W-1:0]       evt_index,
    output logic                   evt_release,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic                   evt_overflow,
    output logic [ROWS*COLS-1:0]   key_state
);

    localparam int c_KEYS    = ROWS * COLS;
    localparam int c_PRESC_W = $clog2(SCAN_DIV);
    localparam int c_COL_W   = $clog2(COLS);
    localparam int c_CNT_W   = 4;
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);

    logic                   r_active;
    logic [ROWS-1:0]        r_row_meta;
    logic [ROWS-1:0]        r_row_sync;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [c_COL_W-1:0]     r_col;
    logic [c_CNT_W-1:0]     r_cnt [c_KEYS];
    logic [c_KEYS-1:0]      r_key_state;

    logic                   w_run;
    logic                   w_tick;
    logic [c_CNT_W-1:0]     w_cnt_nxt [c_KEYS];
    logic [c_KEYS-1:0]      w_state_nxt;
    logic                   w_fire;
    logic [IDX_W-1:0]       w_fire_idx;
    logic                   w_fire_rel;
    logic                   w_raw;
    int                     w_k;
    logic                   w_push;

    logic [IDX_W-1:0]       r_mem_idx [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr;
    logic [c_PTR_W-1:0]     r_rd;
    logic [c_PTR_W:0]       r_count;
    logic                   r_overflow;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr;

    // r_active delays the first driven column by one clk so that reset forces all columns high
    // and every (re)start of the scan begins with a full-length column-0 period.
    assign w_run  = en & r_active;
    assign w_tick = w_run & (r_presc == c_PRESC_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active   <= 1'b0;
            r_row_meta <= '1;
            r_row_sync <= '1;
        end else begin
            r_active   <= en;
            r_row_meta <= keypad_row;
            r_row_sync <= r_row_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_col   <= '0;
        end else if (!w_run) begin
            r_presc <= '0;
            r_col   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_col   <= (r_col == c_COL_W'(COLS - 1)) ? '0 : r_col + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_comb begin
        keypad_col = '1;
        if (w_run) begin
            keypad_col[r_col] = 1'b0;
        end
    end

    // Only one key may toggle per tick; a second key ready in the same column holds its count
    // at the threshold and toggles on its next disagreeing sample, so no event is ever lost.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_key_state;
        w_fire      = 1'b0;
        w_fire_idx  = '0;
        w_fire_rel  = 1'b0;
        w_raw       = 1'b0;
        w_k         = 0;
        if (!w_run) begin
            for (int k = 0; k < c_KEYS; k++) begin
                w_cnt_nxt[k] = '0;
            end
        end else if (w_tick) begin
            for (int r = 0; r < ROWS; r++) begin
                w_k   = r * COLS + int'(r_col);
                w_raw = ~r_row_sync[r];
                if (w_raw == r_key_state[w_k]) begin
                    w_cnt_nxt[w_k] = '0;
                end else if (r_cnt[w_k] == c_CNT_W'(DEBOUNCE - 1)) begin
                    if (!w_fire) begin
                        w_state_nxt[w_k] = w_raw;
                        w_cnt_nxt[w_k]   = '0;
                        w_fire           = 1'b1;
                        w_fire_idx       = IDX_W'(w_k);
                        w_fire_rel       = ~w_raw;
                    end else begin
                        w_cnt_nxt[w_k] = c_CNT_W'(DEBOUNCE - 1);
                    end
                end else begin
                    w_cnt_nxt[w_k] = r_cnt[w_k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < c_KEYS; k++) begin
                r_cnt[k] <= '0;
            end
            r_key_state <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_key_state <= w_state_nxt;
        end
    end

`ifdef KEYPAD_RELEASE_EVT_EN
    logic [FIFO_DEPTH-1:0]  r_mem_rel;

    assign w_push = w_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_rel <= '0;
        end else if (w_wr) begin
            r_mem_rel[r_wr] <= w_fire_rel;
        end
    end

    assign evt_release = r_mem_rel[r_rd];
`else
    assign w_push      = w_fire & ~w_fire_rel;
    assign evt_release = 1'b0;
`endif

    assign w_full = (r_count == (c_PTR_W + 1)'(FIFO_DEPTH));
    assign w_pop  = (r_count != '0) & evt_ready;
    assign w_wr   = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_idx[i] <= '0;
            end
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem_idx[r_wr] <= w_fire_idx;
                r_wr            <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_pop & (r_count == (c_PTR_W + 1)'(1)) & ~w_wr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign evt_valid    = (r_count != '0);
    assign evt_index    = r_mem_idx[r_rd];
    assign evt_overflow = r_overflow;
    assign key_state    = r_key_state;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// +------------------------------------------------------------------------------------------+
// | tb_keypad_matrix_scanner                                                                  |
// | Directed self-checking bench for keypad_matrix_scanner (4x4, SCAN_DIV=4, DEBOUNCE=3).      |
// | Revision: 1.0                                                                             |
// +------------------------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_keypad_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        evt_ready;
    logic [3:0]  keypad_col;
    logic [3:0]  keypad_row;
    logic [3:0]  evt_index;
    logic        evt_release;
    logic        evt_valid;
    logic        evt_overflow;
    logic [15:0] key_state;
    logic [15:0] pressed;

    int n_tests = 0;
    int n_fail  = 0;

    keypad_matrix_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .keypad_col(keypad_col), .keypad_row(keypad_row),
        .evt_index(evt_index), .evt_release(evt_release), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_overflow(evt_overflow), .key_state(key_state)
    );

    always #5 clk = ~clk;

    // Passive matrix: a row reads low when a held key sits on a column currently driven low.
    always_comb begin
        keypad_row = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !keypad_col[c]) keypad_row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic wait_key(input int k, input logic v, input int budget, input string tag);
        int i = 0;
        while (key_state[k] !== v && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, key_state[k], v);
    endtask

    task automatic press_wait(input int k, input string tag);
        pressed[k] = 1'b1;
        wait_key(k, 1'b1, 80, tag);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int i = 0;
        while (evt_valid !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, evt_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        int         q_a [4];
        int         q_b [4];
        int         ia;
        q_a = '{0, 5, 10, 15};
        q_b = '{2, 4, 7, 8};
        pressed   = '0;
        rst       = 1'b1;
        en        = 1'b1;
        evt_ready = 1'b0;
        tick(3);
        check("rst_col",      keypad_col,   4'hF);
        check("rst_valid",    evt_valid,    1'b0);
        check("rst_overflow", evt_overflow, 1'b0);
        check("rst_index",    evt_index,    4'h0);
        check("rst_release",  evt_release,  1'b0);
        check("rst_state",    key_state,    16'h0);
        rst = 1'b0;

        // column walk, each held 4 clks, then wrap
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            exp_col = 4'hF;
            exp_col[(i / 4) % 4] = 1'b0;
            check("scan_col", keypad_col, exp_col);
        end

        // press idx 6 (row1/col2)
        pressed[6] = 1'b1;
        tick(32);
        check("press6_early", evt_valid, 1'b0);
        wait_valid(40, "press6_valid");
        check("press6_index",   evt_index,   4'd6);
        check("press6_release", evt_release, 1'b0);
        check("press6_state",   key_state,   16'h0040);
        pop_one();
        check("press6_popped", evt_valid, 1'b0);

        // two-scan bounce on idx 9
        pressed[9] = 1'b1;
        tick(28);
        pressed[9] = 1'b0;
        tick(48);
        check("bounce_valid", evt_valid, 1'b0);
        check("bounce_state", key_state, 16'h0040);

        // release idx 6
        pressed[6] = 1'b0;
        tick(32);
        check("rel6_hold", key_state[6], 1'b1);
        wait_key(6, 1'b0, 50, "rel6_state");
`ifdef KEYPAD_RELEASE_EVT_EN
        check("rel6_valid",   evt_valid,   1'b1);
        check("rel6_index",   evt_index,   4'd6);
        check("rel6_release", evt_release, 1'b1);
        pop_one();
`else
        check("rel6_noevt", evt_valid, 1'b0);
`endif

        // five presses into a 4-deep FIFO with no consumer
        press_wait(0,  "ovf_p0");
        press_wait(5,  "ovf_p5");
        press_wait(10, "ovf_p10");
        press_wait(15, "ovf_p15");
        press_wait(3,  "ovf_p3");
        check("ovf_valid", evt_valid,    1'b1);
        check("ovf_flag",  evt_overflow, 1'b1);
        for (int j = 0; j < 4; j++) begin
            check("drain_index",   evt_index,    q_a[j]);
            check("drain_release", evt_release,  1'b0);
            check("drain_ovf",     evt_overflow, 1'b1);
            pop_one();
        end
        check("drain_empty",   evt_valid,    1'b0);
        check("drain_ovf_clr", evt_overflow, 1'b0);

        // release everything while consuming freely
        evt_ready = 1'b1;
        pressed   = '0;
        wait_key(0,  1'b0, 80, "clr0");
        wait_key(5,  1'b0, 80, "clr5");
        wait_key(10, 1'b0, 80, "clr10");
        wait_key(15, 1'b0, 80, "clr15");
        wait_key(3,  1'b0, 80, "clr3");
        tick(2);
        evt_ready = 1'b0;
        check("clr_empty", evt_valid,    1'b0);
        check("clr_ovf",   evt_overflow, 1'b0);

        // full FIFO, push and pop in the same clk
        press_wait(1, "full_p1");
        press_wait(2, "full_p2");
        press_wait(4, "full_p4");
        press_wait(7, "full_p7");
        ia = 0;
        while (keypad_col !== 4'b1110 && ia < 40) begin @(negedge clk); ia++; end
        while (keypad_col !== 4'b1101 && ia < 40) begin @(negedge clk); ia++; end
        check("align_col1", keypad_col, 4'b1101);
        pressed[8] = 1'b1;
        tick(47);
        check("align_col0",  keypad_col,   4'b1110);
        check("pp_pre_state", key_state[8], 1'b0);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("pp_state", key_state[8], 1'b1);
        check("pp_valid", evt_valid,    1'b1);
        check("pp_ovf",   evt_overflow, 1'b0);
        for (int j = 0; j < 4; j++) begin
            check("pp_index", evt_index,    q_b[j]);
            check("pp_ovf_q", evt_overflow, 1'b0);
            pop_one();
        end
        check("pp_empty", evt_valid, 1'b0);

        // reset with two queued events
        evt_ready = 1'b1;
        pressed   = '0;
        wait_key(8, 1'b0, 80, "clr8");
        wait_key(1, 1'b0, 80, "clr1");
        tick(2);
        evt_ready = 1'b0;
        press_wait(12, "q_p12");
        press_wait(13, "q_p13");
        check("q_valid", evt_valid, 1'b1);
        pressed = '0;
        tick(1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", evt_valid,  1'b0);
        check("mid_rst_col",   keypad_col, 4'hF);
        check("mid_rst_state", key_state,  16'h0);
        @(negedge clk);
        rst = 1'b0;
        tick(4);
        check("post_rst_valid", evt_valid, 1'b0);

        // drop en in the middle of debouncing idx 11
        press_wait(6, "en_p6");
        pop_one();
        pressed[11] = 1'b1;
        tick(20);
        en = 1'b0;
        @(negedge clk);
        check("en0_col",   keypad_col, 4'hF);
        check("en0_state", key_state,  16'h0040);
        tick(5);
        en = 1'b1;
        @(negedge clk);
        check("reen_col", keypad_col, 4'b1110);
        tick(39);
        check("reen_early", key_state[11], 1'b0);
        tick(16);
        check("reen_state", key_state[11], 1'b1);
        check("reen_valid", evt_valid,     1'b1);
        check("reen_index", evt_index,     4'd11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
